// File: rtl/ctrl_sequencer_pkg.sv
// Shared constants for the hardwired control sequencer: state codes, opcodes,
// IR field positions and the opcode classifier.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_WAIT = 4'd6,
      S_T5   = 4'd7,
      S_T6   = 4'd8,
      S_HALT = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_MULDIV,
      CLS_NOP,
      CLS_HALT,
      CLS_BAD
   } op_class_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 27;
   localparam int unsigned RA_HI  = 26;
   localparam int unsigned RA_LO  = 23;
   localparam int unsigned RB_HI  = 22;
   localparam int unsigned RB_LO  = 19;
   localparam int unsigned RC_HI  = 18;
   localparam int unsigned RC_LO  = 15;

   function automatic op_class_t classify(input logic [4:0] opc);
      op_class_t cls;
      if (opc >= OP_ADD && opc <= OP_OR)
         cls = CLS_ALU;
      else if (opc == OP_MUL || opc == OP_DIV)
         cls = CLS_MULDIV;
      else if (opc == OP_NOP)
         cls = CLS_NOP;
      else if (opc == OP_HALT)
         cls = CLS_HALT;
      else
         cls = CLS_BAD;
      return cls;
   endfunction

endpackage

// File: rtl/ctrl_sequencer_ir_decoder.sv
// Combinational instruction decode: opcode class plus register fields.
module ir_decoder
   import ctrl_pkg::*;
(
   input  logic [31:0] IR,
   output op_class_t   op_class,
   output logic [4:0]  opcode,
   output logic [3:0]  ra,
   output logic [3:0]  rb,
   output logic [3:0]  rc
);

   logic unused_ir_low;

   assign opcode        = IR[OPC_HI:OPC_LO];
   assign ra            = IR[RA_HI:RA_LO];
   assign rb            = IR[RB_HI:RB_LO];
   assign rc            = IR[RC_HI:RC_LO];
   assign op_class      = classify(opcode);
   assign unused_ir_low = ^IR[RC_LO-1:0];

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for the DataPath. Optional ALU wait
// timeout is enabled by defining ALU_TIMEOUT_EN.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)(
   input  logic        Clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] IR,
   input  logic        finished,
   output logic        RFout,
   output logic        PCout,
   output logic        IRout,
   output logic        RYout,
   output logic        RZLOout,
   output logic        RZHIout,
   output logic        MARout,
   output logic        RHIout,
   output logic        RLOout,
   output logic        MDRout,
   output logic        RFin,
   output logic        PCin,
   output logic        IRin,
   output logic        RYin,
   output logic        RZin,
   output logic        MARin,
   output logic        RHIin,
   output logic        RLOin,
   output logic        MDRin,
   output logic [4:0]  RFSelect,
   output logic [5:0]  opSelect,
   output logic        start,
   output logic        Read,
   output logic        IncPC,
   output logic [3:0]  stateOut,
   output logic        illegal,
   output logic        halted
);

   state_t    state;
   state_t    next_fetch;
   op_class_t op_class;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;

   ir_decoder u_dec (
      .IR       (IR),
      .op_class (op_class),
      .opcode   (opcode),
      .ra       (ra),
      .rb       (rb),
      .rc       (rc)
   );

   assign next_fetch = run ? S_T0 : S_IDLE;

`ifdef ALU_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] wait_cnt;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge Clock) begin
      if (clear) begin
         state   <= S_IDLE;
         illegal <= 1'b0;
`ifdef ALU_TIMEOUT_EN
         wait_cnt <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (run) state <= S_T0;
            S_T0:   state <= S_T1;
            S_T1:   state <= S_T2;
            S_T2:   state <= S_T3;
            S_T3: begin
               case (op_class)
                  CLS_ALU, CLS_MULDIV: state <= S_T4;
                  CLS_HALT:            state <= S_HALT;
                  CLS_BAD: begin
                     illegal <= 1'b1;
                     state   <= next_fetch;
                  end
                  default:             state <= next_fetch;
               endcase
            end
            S_T4: begin
               state <= S_WAIT;
`ifdef ALU_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            S_WAIT: begin
               if (finished)
                  state <= S_T5;
`ifdef ALU_TIMEOUT_EN
               // Give up after TIMEOUT_CYCLES waiting cycles; no writeback follows.
               else if (wait_cnt == WAIT_LAST) begin
                  illegal <= 1'b1;
                  state   <= next_fetch;
               end else
                  wait_cnt <= wait_cnt + 1'b1;
`endif
            end
            S_T5:   state <= (op_class == CLS_MULDIV) ? S_T6 : next_fetch;
            S_T6:   state <= next_fetch;
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs depend on the IR fields as well as the state, so they are
   // decoded here rather than registered ahead of the IR load.
   always_comb begin
      RFout    = 1'b0;
      PCout    = 1'b0;
      IRout    = 1'b0;
      RYout    = 1'b0;
      RZLOout  = 1'b0;
      RZHIout  = 1'b0;
      MARout   = 1'b0;
      RHIout   = 1'b0;
      RLOout   = 1'b0;
      MDRout   = 1'b0;
      RFin     = 1'b0;
      PCin     = 1'b0;
      IRin     = 1'b0;
      RYin     = 1'b0;
      RZin     = 1'b0;
      MARin    = 1'b0;
      RHIin    = 1'b0;
      RLOin    = 1'b0;
      MDRin    = 1'b0;
      RFSelect = '0;
      opSelect = '0;
      start    = 1'b0;
      Read     = 1'b0;
      IncPC    = 1'b0;
      halted   = 1'b0;
      case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            RZin  = 1'b1;
         end
         S_T1: begin
            RZLOout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            if (op_class == CLS_ALU || op_class == CLS_MULDIV) begin
               RFout    = 1'b1;
               RFSelect = {1'b0, rb};
               RYin     = 1'b1;
            end
         end
         S_T4: begin
            RFout    = 1'b1;
            RFSelect = {1'b0, rc};
            RZin     = 1'b1;
            start    = 1'b1;
            opSelect = {1'b0, opcode};
         end
         S_WAIT: begin
            RZin     = 1'b1;
            opSelect = {1'b0, opcode};
         end
         S_T5: begin
            RZLOout = 1'b1;
            if (op_class == CLS_MULDIV)
               RLOin = 1'b1;
            else begin
               RFin     = 1'b1;
               RFSelect = {1'b0, ra};
            end
         end
         S_T6: begin
            RZHIout = 1'b1;
            RHIin   = 1'b1;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign stateOut = state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios plus randomized
// instruction streams compared against a cycle-level expectation model.
module tb_ctrl_sequencer;

   logic        Clock = 1'b0;
   logic        clear = 1'b0;
   logic        run = 1'b0;
   logic [31:0] IR = '0;
   logic        finished = 1'b0;
   logic RFout, PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, MDRout;
   logic RFin, PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, MDRin;
   logic [4:0] RFSelect;
   logic [5:0] opSelect;
   logic start, Read, IncPC, illegal, halted;
   logic [3:0] stateOut;

   localparam int TO = 4;

   ctrl_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock), .clear(clear), .run(run), .IR(IR), .finished(finished),
      .RFout(RFout), .PCout(PCout), .IRout(IRout), .RYout(RYout),
      .RZLOout(RZLOout), .RZHIout(RZHIout), .MARout(MARout), .RHIout(RHIout),
      .RLOout(RLOout), .MDRout(MDRout),
      .RFin(RFin), .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin),
      .MARin(MARin), .RHIin(RHIin), .RLOin(RLOin), .MDRin(MDRin),
      .RFSelect(RFSelect), .opSelect(opSelect), .start(start), .Read(Read),
      .IncPC(IncPC), .stateOut(stateOut), .illegal(illegal), .halted(halted)
   );

   always #5 Clock = ~Clock;

   localparam int B_RFOUT = 0, B_PCOUT = 1, B_IROUT = 2, B_RYOUT = 3, B_RZLOOUT = 4;
   localparam int B_RZHIOUT = 5, B_MAROUT = 6, B_RHIOUT = 7, B_RLOOUT = 8, B_MDROUT = 9;
   localparam int B_RFIN = 10, B_PCIN = 11, B_IRIN = 12, B_RYIN = 13, B_RZIN = 14;
   localparam int B_MARIN = 15, B_RHIIN = 16, B_RLOIN = 17, B_MDRIN = 18;
   localparam int B_START = 19, B_READ = 20, B_INCPC = 21, B_HALTED = 22;

   logic [22:0] act;
   assign act = {halted, IncPC, Read, start, MDRin, RLOin, RHIin, MARin, RZin, RYin,
                 IRin, PCin, RFin, MDRout, RLOout, RHIout, MARout, RZHIout, RZLOout,
                 RYout, IRout, PCout, RFout};

   typedef struct {
      logic [22:0] flags;
      logic [4:0]  sel;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [31:0] ir;
      logic        fin;
      logic        run;
      logic        clr;
      logic        set_ill;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_step = 0;
   logic m_ill = 1'b0;
   exp_t q[$];

   function automatic logic [22:0] bt(input int b);
      return 23'(1) << b;
   endfunction

   function automatic exp_t mk(input int st, input logic [22:0] flags, input logic [31:0] ir,
                               input logic r);
      exp_t e;
      e.flags = flags; e.sel = '0; e.op = '0; e.st = 4'(st); e.ir = ir;
      e.fin = 1'($urandom_range(0, 1)); e.run = r; e.clr = 1'b0; e.set_ill = 1'b0;
      return e;
   endfunction

   // 0 alu, 1 mul/div, 2 nop, 3 halt, 4 unsupported
   function automatic int kind_of(input logic [4:0] opc);
      int v;
      v = int'(opc);
      if (v >= 3 && v <= 11) return 0;
      if (v == 14 || v == 15) return 1;
      if (v == 26) return 2;
      if (v == 27) return 3;
      return 4;
   endfunction

   // Queue the cycle-by-cycle expectations for one instruction starting in T0.
   task automatic add_instr(input logic [31:0] ir, input int d, input bit keep_run,
                            input bit timeout);
      exp_t e;
      logic [4:0] opc;
      logic [3:0] ra, rb, rc;
      int k;
      opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
      k = kind_of(opc);
      q.push_back(mk(1, bt(B_PCOUT) | bt(B_MARIN) | bt(B_INCPC) | bt(B_RZIN), ir, 1'b1));
      q.push_back(mk(2, bt(B_RZLOOUT) | bt(B_PCIN) | bt(B_READ) | bt(B_MDRIN), ir, keep_run));
      q.push_back(mk(3, bt(B_MDROUT) | bt(B_IRIN), ir, keep_run));
      if (k <= 1) begin
         e = mk(4, bt(B_RFOUT) | bt(B_RYIN), ir, keep_run);
         e.sel = {1'b0, rb};
      end else begin
         e = mk(4, '0, ir, keep_run);
         e.set_ill = (k == 4);
      end
      q.push_back(e);
      if (k == 3) return;
      if (k <= 1) begin
         e = mk(5, bt(B_RFOUT) | bt(B_RZIN) | bt(B_START), ir, keep_run);
         e.sel = {1'b0, rc}; e.op = {1'b0, opc};
         q.push_back(e);
         if (timeout) begin
            for (int i = 0; i < TO; i++) begin
               e = mk(6, bt(B_RZIN), ir, keep_run);
               e.op = {1'b0, opc}; e.fin = 1'b0; e.set_ill = (i == TO - 1);
               q.push_back(e);
            end
         end else begin
            for (int i = 0; i <= d; i++) begin
               e = mk(6, bt(B_RZIN), ir, keep_run);
               e.op = {1'b0, opc}; e.fin = (i == d);
               q.push_back(e);
            end
            if (k == 0) begin
               e = mk(7, bt(B_RZLOOUT) | bt(B_RFIN), ir, keep_run);
               e.sel = {1'b0, ra};
               q.push_back(e);
            end else begin
               q.push_back(mk(7, bt(B_RZLOOUT) | bt(B_RLOIN), ir, keep_run));
               q.push_back(mk(8, bt(B_RZHIOUT) | bt(B_RHIIN), ir, keep_run));
            end
         end
      end
      if (!keep_run) begin
         for (int i = 0; i < int'($urandom_range(0, 2)); i++)
            q.push_back(mk(0, '0, ir, 1'b0));
         q.push_back(mk(0, '0, ir, 1'b1));
      end
   endtask

   task automatic step(input exp_t e);
      IR = e.ir; finished = e.fin; run = e.run; clear = e.clr;
      #1;
      n_step++;
      n_cmp++;
      if (stateOut !== e.st) begin
         n_bad++;
         $display("FAIL stateOut step %0d: got %0d want %0d", n_step, stateOut, e.st);
      end
      n_cmp++;
      if (act !== e.flags) begin
         n_bad++;
         $display("FAIL controls step %0d st %0d: got %h want %h", n_step, e.st, act, e.flags);
      end
      n_cmp++;
      if (RFSelect !== e.sel) begin
         n_bad++;
         $display("FAIL RFSelect step %0d: got %0d want %0d", n_step, RFSelect, e.sel);
      end
      n_cmp++;
      if (opSelect !== e.op) begin
         n_bad++;
         $display("FAIL opSelect step %0d: got %b want %b", n_step, opSelect, e.op);
      end
      n_cmp++;
      if (illegal !== m_ill) begin
         n_bad++;
         $display("FAIL illegal step %0d: got %b want %b", n_step, illegal, m_ill);
      end
      @(posedge Clock); #1;
      if (e.clr) m_ill = 1'b0;
      else if (e.set_ill) m_ill = 1'b1;
   endtask

   task automatic drain;
      while (q.size() > 0) step(q.pop_front());
      clear = 1'b0;
   endtask

   task automatic do_clear;
      clear = 1'b1; run = 1'b0; finished = 1'b0;
      @(posedge Clock); #1;
      clear = 1'b0; m_ill = 1'b0;
   endtask

   task automatic test_reset;
      clear = 1'b1; run = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      n_cmp++;
      if (stateOut !== 4'd0) begin
         n_bad++; $display("FAIL reset_state: got %0d want 0", stateOut);
      end
      n_cmp++;
      if (act !== '0 || RFSelect !== '0 || opSelect !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got %h/%0d/%0d want 0", act, RFSelect, opSelect);
      end
      n_cmp++;
      if (illegal !== 1'b0) begin
         n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal);
      end
      clear = 1'b0;
      @(posedge Clock); #1;
      n_cmp++;
      if (stateOut !== 4'd1) begin
         n_bad++; $display("FAIL reset_release: got %0d want 1", stateOut);
      end
      do_clear();
   endtask

   task automatic test_shra;
      q.push_back(mk(0, '0, 32'h30918000, 1'b1));
      add_instr(32'h30918000, 2, 1'b0, 1'b0);
      drain();
      do_clear();
   endtask

   task automatic test_mul;
      logic [31:0] ir;
      ir = $urandom;
      ir[31:27] = 5'b01110;
      q.push_back(mk(0, '0, ir, 1'b1));
      add_instr(ir, 0, 1'b1, 1'b0);
      q.push_back(mk(1, bt(B_PCOUT) | bt(B_MARIN) | bt(B_INCPC) | bt(B_RZIN), ir, 1'b0));
      drain();
      do_clear();
   endtask

   task automatic test_illegal_then_wait_clear;
      logic [31:0] ir;
      exp_t e;
      ir = $urandom;
      ir[31:27] = 5'b11111;
      q.push_back(mk(0, '0, ir, 1'b1));
      add_instr(ir, 0, 1'b1, 1'b0);
      ir[31:27] = 5'b00011;
      q.push_back(mk(1, bt(B_PCOUT) | bt(B_MARIN) | bt(B_INCPC) | bt(B_RZIN), ir, 1'b1));
      q.push_back(mk(2, bt(B_RZLOOUT) | bt(B_PCIN) | bt(B_READ) | bt(B_MDRIN), ir, 1'b1));
      q.push_back(mk(3, bt(B_MDROUT) | bt(B_IRIN), ir, 1'b1));
      e = mk(4, bt(B_RFOUT) | bt(B_RYIN), ir, 1'b1); e.sel = {1'b0, ir[22:19]};
      q.push_back(e);
      e = mk(5, bt(B_RFOUT) | bt(B_RZIN) | bt(B_START), ir, 1'b1);
      e.sel = {1'b0, ir[18:15]}; e.op = {1'b0, ir[31:27]};
      q.push_back(e);
      for (int i = 0; i < 3; i++) begin
         e = mk(6, bt(B_RZIN), ir, 1'b1); e.op = {1'b0, ir[31:27]}; e.fin = 1'b0;
         e.clr = (i == 2);
         q.push_back(e);
      end
      e = mk(0, '0, ir, 1'b0); e.fin = 1'b0;
      q.push_back(e);
      drain();
      do_clear();
   endtask

   task automatic test_halt;
      logic [31:0] ir;
      exp_t e;
      ir = $urandom;
      ir[31:27] = 5'b11011;
      q.push_back(mk(0, '0, ir, 1'b1));
      add_instr(ir, 0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) q.push_back(mk(9, bt(B_HALTED), ir, 1'b1));
      e = mk(9, bt(B_HALTED), ir, 1'b1); e.clr = 1'b1;
      q.push_back(e);
      q.push_back(mk(0, '0, ir, 1'b0));
      drain();
      do_clear();
   endtask

`ifdef ALU_TIMEOUT_EN
   task automatic test_timeout;
      logic [31:0] ir;
      ir = $urandom;
      ir[31:27] = 5'(3 + $urandom_range(0, 8));
      q.push_back(mk(0, '0, ir, 1'b1));
      add_instr(ir, 0, 1'b1, 1'b1);
      q.push_back(mk(1, bt(B_PCOUT) | bt(B_MARIN) | bt(B_INCPC) | bt(B_RZIN), ir, 1'b0));
      drain();
      do_clear();
   endtask
   localparam int DMAX = TO - 2;
`else
   localparam int DMAX = 6;
`endif

   task automatic test_random;
      logic [31:0] ir;
      q.push_back(mk(0, '0, 32'h0, 1'b1));
      for (int n = 0; n < 60; n++) begin
         ir = $urandom;
         if (ir[31:27] == 5'b11011) ir[31:27] = 5'b11010;
         if ($urandom_range(0, 2) != 0) ir[31:27] = 5'(3 + $urandom_range(0, 12));
         add_instr(ir, int'($urandom_range(0, DMAX)), ($urandom_range(0, 3) != 0), 1'b0);
      end
      drain();
      do_clear();
   endtask

   initial begin
      test_reset();
      test_shra();
      test_mul();
      test_illegal_then_wait_clear();
      test_halt();
`ifdef ALU_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
